// File: rtl/serial_io_bus_sequencer.sv
// IO-space chip-select sequencer: decodes NUM_PORTS register windows and runs a
// setup/strobe/hold/ack bus cycle. Define SERIAL_IO_RDATA_LATCH_EN to latch read data.
module serial_io_bus_sequencer #(
  parameter int              NUM_PORTS   = 4,
  parameter int              ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(16'h0200),
  parameter int              SPAN_LOG2   = 4,
  parameter int              WAIT_CYCLES = 3,
  parameter int              HOLD_CYCLES = 1
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [ADDR_W-1:0]    Address,
  input  logic                 IOSelect_H,
  input  logic                 ByteSelect_L,
  input  logic                 Read_H,
  input  logic                 Write_H,
  input  logic [7:0]           Port_Data_In,
  output logic [NUM_PORTS-1:0] Port_Enable,
  output logic                 Port_RD_L,
  output logic                 Port_WR_L,
  output logic                 Ack_H,
  output logic                 Decode_Error_H,
  output logic [7:0]           Read_Data
);

  localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int STRB_W = $clog2(WAIT_CYCLES + 1);
  localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_ACK, S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   is_read_q, is_read_d;
  logic [STRB_W-1:0]      strb_cnt_q, strb_cnt_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [NUM_PORTS-1:0]   en_q, en_d;
  logic                   rd_l_q, rd_l_d;
  logic                   wr_l_q, wr_l_d;
  logic                   ack_q, ack_d;
  logic                   derr_q, derr_d;
  logic [7:0]             rdata_q, rdata_d;

  // Window index; addresses below BASE_ADDR are rejected before the index is trusted.
  logic [ADDR_W-1:0] win_idx;
  logic              hit, req_any, req_both;

  assign win_idx  = (Address - BASE_ADDR) >> SPAN_LOG2;
  assign hit      = (Address >= BASE_ADDR) && (win_idx < ADDR_W'(NUM_PORTS)) && !ByteSelect_L;
  assign req_any  = IOSelect_H && (Read_H || Write_H);
  assign req_both = Read_H && Write_H;

`ifndef SERIAL_IO_RDATA_LATCH_EN
  logic unused_port_data;
  assign unused_port_data = ^Port_Data_In;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    is_read_d  = is_read_q;
    strb_cnt_d = strb_cnt_q;
    hold_cnt_d = hold_cnt_q;
    rdata_d    = rdata_q;
    derr_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_any) begin
          if (hit && !req_both) begin
            state_d   = S_SETUP;
            idx_d     = IDX_W'(win_idx);
            is_read_d = Read_H;
          end else begin
            state_d = S_ACK;
            derr_d  = 1'b1;
          end
        end
      end
      S_SETUP: begin
        if (is_read_q ? !Read_H : !Write_H) begin
          state_d = S_IDLE;
        end else begin
          state_d    = S_STROBE;
          strb_cnt_d = STRB_W'(WAIT_CYCLES);
        end
      end
      S_STROBE: begin
        if (strb_cnt_q == STRB_W'(1)) begin
`ifdef SERIAL_IO_RDATA_LATCH_EN
          if (is_read_q) rdata_d = Port_Data_In;
`endif
          if (HOLD_CYCLES == 0) begin
            state_d = S_ACK;
          end else begin
            state_d    = S_HOLD;
            hold_cnt_d = HOLD_W'(HOLD_CYCLES);
          end
        end else begin
          strb_cnt_d = strb_cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == HOLD_W'(1)) state_d = S_ACK;
        else                          hold_cnt_d = hold_cnt_q - 1'b1;
      end
      S_ACK:   state_d = S_DONE;
      S_DONE:  if (!Read_H && !Write_H) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    en_d   = '0;
    rd_l_d = 1'b1;
    wr_l_d = 1'b1;
    ack_d  = 1'b0;
    unique case (state_d)
      S_SETUP, S_HOLD: en_d = NUM_PORTS'(1) << idx_d;
      S_STROBE: begin
        en_d   = NUM_PORTS'(1) << idx_d;
        rd_l_d = !is_read_d;
        wr_l_d = is_read_d;
      end
      S_ACK:   ack_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      is_read_q  <= 1'b0;
      strb_cnt_q <= '0;
      hold_cnt_q <= '0;
      en_q       <= '0;
      rd_l_q     <= 1'b1;
      wr_l_q     <= 1'b1;
      ack_q      <= 1'b0;
      derr_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q    <= state_d;
      idx_q      <= idx_d;
      is_read_q  <= is_read_d;
      strb_cnt_q <= strb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      en_q       <= en_d;
      rd_l_q     <= rd_l_d;
      wr_l_q     <= wr_l_d;
      ack_q      <= ack_d;
      derr_q     <= derr_d;
      rdata_q    <= rdata_d;
    end
  end

  assign Port_Enable    = en_q;
  assign Port_RD_L      = rd_l_q;
  assign Port_WR_L      = wr_l_q;
  assign Ack_H          = ack_q;
  assign Decode_Error_H = derr_q;
  assign Read_Data      = rdata_q;

endmodule
